half_adder: RTL and testbench
=============================

Name: half_adder

Overview:
Registered, lane-parallel half adder. Each of WIDTH independent lanes computes sum = a XOR b and carry c = a AND b. Results are captured on the clock edge with a valid qualifier. Used as a leaf arithmetic cell in adder trees and as a bring-up/checker block; WIDTH=1 gives the classic single-bit half adder.

Parameters:
WIDTH, 1, number of independent 1-bit half-adder lanes (legal range 1..64).

Ports:
clk  input  1  rising-edge clock, single clock domain
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  qualifies a and b this cycle
a  input  WIDTH  addend A, lane i = bit i
b  input  WIDTH  addend B, lane i = bit i
c  output  WIDTH  registered carry-out per lane (a[i] AND b[i])
sum  output  WIDTH  registered sum per lane (a[i] XOR b[i])
out_valid  output  1  c/sum hold a result computed from a qualified input

Behaviour:
- Reset: rst_n is sampled low at a rising clk edge. On that edge, c, sum and out_valid all become 0. Reset has priority over in_valid.
- Reset mid-operation: any in-flight result is discarded. The first cycle after rst_n returns high still shows zeros until a qualified input is captured.
- Latency: 1 cycle. If in_valid=1 at edge N, then at edge N the c/sum registers load lane-wise AND/XOR of a,b, and out_valid loads 1.
- If in_valid=0 at an edge (not in reset): c and sum hold their previous values, and out_valid loads 0.
- Lanes are fully independent. There is no carry propagation between lanes.
- Per-lane truth table (a,b -> c,sum): 0,0->0,0; 0,1->0,1; 1,0->0,1; 1,1->1,0.
- Invariant: for every lane, c and sum are never both 1. Arithmetic value per lane is 2*c + sum = a + b.
- X handling: a/b are don't-care when in_valid=0. The outputs must not be updated from them.
- No backpressure: the block accepts a new input every cycle. Throughput is 1 result per cycle.
- Outputs are driven only by flops, with no combinational path from inputs to outputs.

Decomposition:
- Shared package half_adder_pkg: localparam MAX_WIDTH = 64.
- Shared package half_adder_pkg: a typedef for a packed lane result struct {c, sum}, used by the checker.
- One natural sub-module: half_adder_bit, a purely combinational 1-bit cell (a, b -> c, sum). It is instantiated WIDTH times via generate.
- The top level holds the registers, the valid pipeline and reset logic.

Test Plan:
- WIDTH=1, reset. Hold rst_n=0 for 2 cycles with in_valid=1, a=1, b=1 -> c=0, sum=0, out_valid=0 throughout reset.
- WIDTH=1, exhaustive. After reset, drive in_valid=1 with a,b = 00, 01, 10, 11 on consecutive cycles -> one cycle later c,sum = 00, 01, 01, 10 with out_valid=1 each cycle.
- WIDTH=1, hold. Capture a=1, b=1 (c=1, sum=0), then in_valid=0 with a=0, b=1 for 3 cycles -> c=1, sum=0 held and out_valid=0.
- WIDTH=8, lane independence. a=0xF0, b=0xCC, in_valid=1 -> next cycle c=0xC0, sum=0x3C, out_valid=1.
- WIDTH=8, mid-stream reset. Stream a=0xFF, b=0xFF (c=0xFF, sum=0x00), then assert rst_n=0 for 1 cycle -> c=0x00, sum=0x00, out_valid=0. The next qualified input a=0x01, b=0x00 gives c=0x00, sum=0x01.
- Random WIDTH=16, 1000 cycles with random in_valid. A scoreboard checks 2*c+sum == a+b per lane, c&sum == 0, and the hold behaviour.

Source files
------------

// File: rtl/half_adder_pkg.sv
// -----------------------------------------------------------------------------
// half_adder_pkg
//   Shared definitions for the lane-parallel half adder.
//   - MAX_WIDTH     : largest supported lane count.
//   - lane_result_t : packed per-lane result {c, sum}. The top level collects
//                     the output of each combinational cell into it, and the
//                     lane checker in the top level reads it back.
// -----------------------------------------------------------------------------
package half_adder_pkg;

    localparam int MAX_WIDTH = 64;

    // One lane's result. The arithmetic value of the lane is 2*c + sum.
    typedef struct packed {
        logic c;
        logic sum;
    } lane_result_t;

endpackage : half_adder_pkg

// File: rtl/half_adder_bit.sv
// -----------------------------------------------------------------------------
// half_adder_bit
//   Purely combinational 1-bit half-adder cell. There is no state and no
//   clock.
//
// Ports:
//   a   : in  1  addend A
//   b   : in  1  addend B
//   c   : out 1  carry-out, a AND b
//   sum : out 1  sum bit,   a XOR b
// -----------------------------------------------------------------------------
module half_adder_bit (
    input  logic a,
    input  logic b,
    output logic c,
    output logic sum
);

    assign c   = a & b;
    assign sum = a ^ b;

endmodule : half_adder_bit

// File: rtl/half_adder.sv
// -----------------------------------------------------------------------------
// half_adder
//   Registered, lane-parallel half adder. Each of WIDTH lanes is independent:
//   no carry moves between lanes. The results are registered with one cycle
//   of latency and carry a valid qualifier. WIDTH=1 is the classic half adder.
//
// Parameters:
//   WIDTH     : number of 1-bit lanes (1..MAX_WIDTH)
//
// Ports:
//   clk       : in  1      rising-edge clock
//   rst_n     : in  1      synchronous active-low reset. It has priority over
//                          in_valid.
//   in_valid  : in  1      qualifies a/b this cycle
//   a         : in  WIDTH  addend A, lane i = bit i
//   b         : in  WIDTH  addend B, lane i = bit i
//   c         : out WIDTH  registered carry per lane
//   sum       : out WIDTH  registered sum per lane
//   out_valid : out 1      c/sum hold a result from a qualified input
//
// Handshake: valid-only, with no backpressure. When in_valid is high at a
//   rising edge, a/b are consumed on that edge. On the same edge c/sum load
//   the lane results and out_valid goes high for the following cycle. When
//   in_valid is low at an edge, a/b are ignored, c/sum keep their previous
//   values and out_valid goes low. A new input can be accepted every cycle.
//   All outputs come straight from flops.
// -----------------------------------------------------------------------------
module half_adder
    import half_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] sum,
    output logic             out_valid
);

    // Combinational result of every lane before the output registers.
    lane_result_t [WIDTH-1:0] lane_next;

    // Registered result of every lane. The checker below reads this.
    lane_result_t [WIDTH-1:0] lane_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_bit u_bit (
            .a   (a[i]),
            .b   (b[i]),
            .c   (lane_next[i].c),
            .sum (lane_next[i].sum)
        );
    end : g_lane

    // Output registers. The data flops load only on a qualified input, so
    // a/b never reach the outputs while in_valid is low, even if a/b are
    // unknown. out_valid follows in_valid every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c         <= '0;
            sum       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < WIDTH; i++) begin
                    c[i]   <= lane_next[i].c;
                    sum[i] <= lane_next[i].sum;
                end
            end
        end
    end

    always_comb begin
        lane_q = '0;
        for (int i = 0; i < WIDTH; i++) begin
            lane_q[i].c   = c[i];
            lane_q[i].sum = sum[i];
        end
    end

    // Lane invariant: a half adder can never produce both a carry and a sum.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chk
        a_lane_exclusive : assert property (
            @(posedge clk) !(lane_q[i].c && lane_q[i].sum)
        );
    end : g_chk

endmodule : half_adder

// File: tb/tb_half_adder.sv
// -----------------------------------------------------------------------------
// tb_half_adder
//   Three instances of half_adder, with WIDTH = 1, 8 and 16, share one clock
//   and one reset. The driver applies directed vectors with hand-computed
//   results and then a random stream on the 16-lane instance.
//
//   Each accepted input pushes its expected {c, sum} into that instance's
//   queue. A monitor per instance runs on the falling edge. It expects
//   out_valid exactly when its queue holds an entry, and then pops and
//   compares. Otherwise it checks that c/sum still hold the last result, or
//   zero after a reset. It also checks c & sum == 0 on every cycle.
// -----------------------------------------------------------------------------
module tb_half_adder;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic rst_seen;   // rst_n was low at the most recent rising edge
    logic mon_en;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic        in_valid1, ov1;
    logic [0:0]  a1, b1, c1, s1;
    logic        in_valid8, ov8;
    logic [7:0]  a8, b8, c8, s8;
    logic        in_valid16, ov16;
    logic [15:0] a16, b16, c16, s16;

    half_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .a(a1), .b(b1),
        .c(c1), .sum(s1), .out_valid(ov1)
    );
    half_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .a(a8), .b(b8),
        .c(c8), .sum(s8), .out_valid(ov8)
    );
    half_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .a(a16), .b(b16),
        .c(c16), .sum(s16), .out_valid(ov16)
    );

    // ---------------- scoreboard state ----------------
    logic [1:0]  exp_q1[$];
    logic [15:0] exp_q8[$];
    logic [31:0] exp_q16[$];
    logic [1:0]  e1;    // expected {c, sum} for the pending drive
    logic [15:0] e8;
    logic [31:0] e16;
    int checks;
    int failures;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h time=%0t",
                     name, act, req, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one rising edge. An entry is pushed only for an input that the
    // DUT really accepts, which means in_valid high and reset released.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (in_valid1)  exp_q1.push_back(e1);
            if (in_valid8)  exp_q8.push_back(e8);
            if (in_valid16) exp_q16.push_back(e16);
        end
        #1;
    endtask

    // Idle inputs carry random junk that the DUT must ignore.
    task automatic idle_all();
        in_valid1  = 1'b0; a1  = 1'($urandom);  b1  = 1'($urandom);
        in_valid8  = 1'b0; a8  = 8'($urandom);  b8  = 8'($urandom);
        in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    endtask

    task automatic set1(input logic v, input logic a, input logic b,
                        input logic ec, input logic es);
        in_valid1 = v; a1 = a; b1 = b; e1 = {ec, es};
    endtask

    task automatic set8(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ec, input logic [7:0] es);
        in_valid8 = v; a8 = a; b8 = b; e8 = {ec, es};
    endtask

    // For random traffic the expected lane result is the 2-bit sum a[i]+b[i],
    // split into carry and sum.
    task automatic set16_rand();
        logic [15:0] ra, rb, ec, es;
        logic [1:0]  lane;
        ra = 16'($urandom);
        rb = 16'($urandom);
        for (int i = 0; i < 16; i++) begin
            lane  = {1'b0, ra[i]} + {1'b0, rb[i]};
            ec[i] = lane[1];
            es[i] = lane[0];
        end
        in_valid16 = 1'($urandom_range(0, 1));
        a16 = ra; b16 = rb; e16 = {ec, es};
    endtask

    // ---------------- monitors ----------------
    always @(posedge clk) rst_seen <= !rst_n;

    initial begin : mon1
        logic [1:0] hold;
        logic       ev;
        hold = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rst_seen) hold = '0;
                ev = (exp_q1.size() != 0);
                check("w1_out_valid", 32'(ov1), 32'(ev));
                if (ev) begin
                    hold = exp_q1.pop_front();
                    check("w1_result", 32'({c1, s1}), 32'(hold));
                end else begin
                    check("w1_hold", 32'({c1, s1}), 32'(hold));
                end
                check("w1_c_and_sum", 32'(c1 & s1), 32'd0);
            end
        end
    end

    initial begin : mon8
        logic [15:0] hold;
        logic        ev;
        hold = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rst_seen) hold = '0;
                ev = (exp_q8.size() != 0);
                check("w8_out_valid", 32'(ov8), 32'(ev));
                if (ev) begin
                    hold = exp_q8.pop_front();
                    check("w8_result", 32'({c8, s8}), 32'(hold));
                end else begin
                    check("w8_hold", 32'({c8, s8}), 32'(hold));
                end
                check("w8_c_and_sum", 32'(c8 & s8), 32'd0);
            end
        end
    end

    initial begin : mon16
        logic [31:0] hold;
        logic        ev;
        hold = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rst_seen) hold = '0;
                ev = (exp_q16.size() != 0);
                check("w16_out_valid", 32'(ov16), 32'(ev));
                if (ev) begin
                    hold = exp_q16.pop_front();
                    check("w16_result", {c16, s16}, hold);
                end else begin
                    check("w16_hold", {c16, s16}, hold);
                end
                check("w16_c_and_sum", 32'(c16 & s16), 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks   = 0;
        failures = 0;
        mon_en   = 1'b0;
        e1 = '0; e8 = '0; e16 = '0;
        idle_all();

        // Reset held for 2 cycles while qualified 1+1 is presented.
        rst_n = 1'b0;
        set1(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        mon_en = 1'b1;
        tick();

        // Release the reset. The first cycle still shows zeros.
        rst_n = 1'b1;
        idle_all();
        tick();

        // WIDTH=1 exhaustive truth table on consecutive cycles.
        set1(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        set1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1); tick();
        set1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1); tick();
        set1(1'b1, 1'b1, 1'b1, 1'b1, 1'b0); tick();

        // Hold: capture 1+1, then 3 unqualified cycles with a=0, b=1.
        set1(1'b1, 1'b1, 1'b1, 1'b1, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            set1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        idle_all();

        // WIDTH=8 lane independence.
        set8(1'b1, 8'hF0, 8'hCC, 8'hC0, 8'h3C); tick();
        idle_all(); tick();

        // WIDTH=8 mid-stream reset.
        set8(1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h00); tick();
        rst_n = 1'b0;
        set8(1'b1, 8'hAA, 8'h55, 8'h00, 8'hFF); tick();
        rst_n = 1'b1;
        set8(1'b1, 8'h01, 8'h00, 8'h00, 8'h01); tick();
        idle_all(); tick();
        idle_all(); tick();

        // WIDTH=16 random stream with random in_valid.
        for (int i = 0; i < 1000; i++) begin
            set16_rand();
            tick();
        end
        idle_all();
        tick();
        tick();
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_half_adder
